// File: rtl/dmac_pkg.sv
// -----------------------------------------------------------------------------
// dmac_pkg
//   Shared definitions for the multi-channel DMA controller: the controller
//   state encoding and the per-channel transfer-mode constants.
// -----------------------------------------------------------------------------
package dmac_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ARB  = 3'd1,
      BREQ = 3'd2,
      RD   = 3'd3,
      WR   = 3'd4,
      NEXT = 3'd5,
      DONE = 3'd6
   } dmac_state_t;

   // Transfer mode held per channel (cfg_blk encoding)
   localparam logic SINGLE = 1'b0;   // one word per bus grant
   localparam logic BLOCK  = 1'b1;   // keep the bus until the count is exhausted

endpackage

// File: rtl/dmac_rr_arb.sv
// -----------------------------------------------------------------------------
// dmac_rr_arb
//   Combinational round-robin selector. Searches the pending vector starting
//   at last+1 (mod NCH) and returns the first set position.
//
//   Ports
//     pending  in   NCH          channels ready for service
//     last     in   clog2(NCH)   channel served most recently
//     gnt_idx  out  clog2(NCH)   selected channel (0 when nothing pending)
//     gnt_vld  out  1            at least one channel pending
// -----------------------------------------------------------------------------
module dmac_rr_arb #(
   parameter int NCH = 4
) (
   input  logic [NCH-1:0]         pending,
   input  logic [$clog2(NCH)-1:0] last,
   output logic [$clog2(NCH)-1:0] gnt_idx,
   output logic                   gnt_vld
);

   localparam int CHW = $clog2(NCH);

   always_comb begin
      int c;
      c       = 0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      // Walk from the farthest distance back to the nearest so the closest
      // pending channel after 'last' is the final (winning) assignment.
      for (int k = NCH; k >= 1; k--) begin
         c = int'(last) + k;
         if (c >= NCH) c = c - NCH;
         if (pending[c]) begin
            gnt_idx = CHW'(c);
            gnt_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dmac_multi.sv
// -----------------------------------------------------------------------------
// dmac_multi
//   Multi-channel DMA controller. Each channel holds a source/destination
//   address, word count, mode and enable. Channels with an active peripheral
//   request are served round-robin; each word is moved with one read and one
//   write on a shared memory bus obtained through bus_req/bus_gnt.
//
//   Ports
//     clk      in   1            clock, rising edge
//     rst      in   1            asynchronous reset, active low
//     req      in   NCH          per-channel peripheral request (level)
//     cfg_we   in   1            channel configuration write strobe
//     cfg_ch   in   clog2(NCH)   channel written by cfg_we
//     cfg_src  in   AW           start source address
//     cfg_dst  in   AW           start destination address
//     cfg_len  in   CW           words to move (0 disables the channel)
//     cfg_blk  in   1            BLOCK / SINGLE mode
//     bus_req  out  1            bus request
//     bus_gnt  in   1            bus grant
//     rd_en    out  1            memory read strobe
//     wr_en    out  1            memory write strobe
//     addr     out  AW           memory address
//     wdata    out  DW           memory write data
//     rdata    in   DW           memory read data
//     mem_ack  in   1            memory access acknowledge
//     done     out  NCH          one-cycle completion pulse per channel
//     busy     out  1            controller not idle
//     act_ch   out  clog2(NCH)   channel latched by the last arbitration
// -----------------------------------------------------------------------------
module dmac_multi
   import dmac_pkg::*;
#(
   parameter int NCH = 4,
   parameter int AW  = 16,
   parameter int DW  = 8,
   parameter int CW  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NCH-1:0]         req,
   input  logic                   cfg_we,
   input  logic [$clog2(NCH)-1:0] cfg_ch,
   input  logic [AW-1:0]          cfg_src,
   input  logic [AW-1:0]          cfg_dst,
   input  logic [CW-1:0]          cfg_len,
   input  logic                   cfg_blk,
   output logic                   bus_req,
   input  logic                   bus_gnt,
   output logic                   rd_en,
   output logic                   wr_en,
   output logic [AW-1:0]          addr,
   output logic [DW-1:0]          wdata,
   input  logic [DW-1:0]          rdata,
   input  logic                   mem_ack,
   output logic [NCH-1:0]         done,
   output logic                   busy,
   output logic [$clog2(NCH)-1:0] act_ch
);

   localparam int CHW = $clog2(NCH);

   dmac_state_t     state, state_nxt;
   logic [CHW-1:0]  act_r;
   logic [CHW-1:0]  last_r;
   logic [DW-1:0]   data_r;

   logic [AW-1:0]   src_r [NCH];
   logic [AW-1:0]   dst_r [NCH];
   logic [CW-1:0]   cnt_r [NCH];
   logic [NCH-1:0]  blk_r;
   logic [NCH-1:0]  en_r;

   logic [NCH-1:0]  pending;
   logic [CHW-1:0]  arb_idx;
   logic            arb_vld;
   logic [CW-1:0]   cnt_dec;
   logic [CHW-1:0]  svc_ch;
   logic            cfg_ok;
   logic            single_release;

   assign pending = req & en_r;

   dmac_rr_arb #(.NCH(NCH)) u_arb (
      .pending (pending),
      .last    (last_r),
      .gnt_idx (arb_idx),
      .gnt_vld (arb_vld)
   );

   assign cnt_dec = cnt_r[act_r] - CW'(1);

   // In ARB the channel being picked is already considered in service, so a
   // write to it cannot slip in between selection and the first word.
   assign svc_ch = (state == ARB) ? arb_idx : act_r;
   assign cfg_ok = cfg_we && !((state != IDLE) && (cfg_ch == svc_ch));

   // NEXT in single mode with words still left: give the bus back.
   assign single_release = (state == NEXT) && (cnt_dec != '0) &&
                           (blk_r[act_r] == SINGLE);

   // ---------------------------------------------------------------------
   // Controller state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         act_r  <= '0;
         last_r <= CHW'(NCH - 1);
         data_r <= '0;
      end else begin
         state <= state_nxt;
         if (state == ARB && arb_vld) act_r <= arb_idx;
         if (state == RD && mem_ack)  data_r <= rdata;
         if (single_release || state == DONE) last_r <= act_r;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (|pending) state_nxt = ARB;
         // Requests may drop between IDLE and ARB; fall back if none remain.
         ARB:  state_nxt = arb_vld ? BREQ : IDLE;
         BREQ: if (bus_gnt) state_nxt = RD;
         RD:   if (mem_ack) state_nxt = WR;
         WR:   if (mem_ack) state_nxt = NEXT;
         NEXT: begin
            if (cnt_dec == '0)                 state_nxt = DONE;
            else if (blk_r[act_r] == BLOCK)    state_nxt = RD;
            else                               state_nxt = IDLE;
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Bus and status outputs, decoded from the current state
   // ---------------------------------------------------------------------
   always_comb begin
      bus_req = (state == BREQ) || (state == RD) || (state == WR) ||
                (state == NEXT);
      rd_en   = (state == RD);
      wr_en   = (state == WR);
      busy    = (state != IDLE);
      addr    = '0;
      wdata   = '0;
      done    = '0;
      case (state)
         RD:   addr = src_r[act_r];
         WR: begin
            addr  = dst_r[act_r];
            wdata = data_r;
         end
         DONE: done[act_r] = 1'b1;
         default: ;
      endcase
   end

   assign act_ch = act_r;

   // ---------------------------------------------------------------------
   // Per-channel registers: configuration load, word advance, completion
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < NCH; c++) begin
            src_r[c] <= '0;
            dst_r[c] <= '0;
            cnt_r[c] <= '0;
         end
         blk_r <= '0;
         en_r  <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            // cfg_ok already excludes the in-service channel, so a load never
            // collides with the NEXT/DONE updates of the same channel.
            if (cfg_ok && cfg_ch == CHW'(c)) begin
               src_r[c] <= cfg_src;
               dst_r[c] <= cfg_dst;
               cnt_r[c] <= cfg_len;
               blk_r[c] <= (cfg_blk == BLOCK);
               en_r[c]  <= (cfg_len != '0);
            end else if (state == NEXT && act_r == CHW'(c)) begin
               src_r[c] <= src_r[c] + AW'(1);
               dst_r[c] <= dst_r[c] + AW'(1);
               cnt_r[c] <= cnt_dec;
            end else if (state == DONE && act_r == CHW'(c)) begin
               en_r[c] <= 1'b0;
            end
         end
      end
   end

endmodule
